mul_hilo_ctrl: RTL and testbench

- Issue and writeback controller for the 2-stage pipelined 32x32 multiplier (`Mul`) in the CPU execute stage.
- Accepts one multiply per cycle from the pipeline and drives the multiplier operands.
- Tracks in-flight operations through a valid/sign shift pipe and retires each 64-bit product in order into architectural HI/LO registers.
- Services MTHI/MTLO writes; generates a stall for MFHI/MFLO until all in-flight products have retired.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_sign_fix.sv | 23 ++
 rtl/mul_hilo_ctrl.sv | 132 +++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the multiply issue/writeback slice.
//   MUL_LAT : latency of the external Mul block (operands -> product), clocks
//   MUL_W   : operand width
//   prod_t  : full-width product type (2*MUL_W bits)
package mul_pkg;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned MUL_W   = 32;

  typedef logic [2*MUL_W-1:0] prod_t;

endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: combinational conditional two's-complement negate of a product.
// Ports:
//   neg_i  : 1 = negate prod_i
//   prod_i : unsigned magnitude product
//   prod_o : prod_i or -prod_i (modulo 2^PW)
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int unsigned PW = 2 * MUL_W
) (
  input  logic          neg_i,
  input  logic [PW-1:0] prod_i,
  output logic [PW-1:0] prod_o
);

  always_comb begin
    prod_o = prod_i;
    if (neg_i) begin
      prod_o = (~prod_i) + {{(PW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: issue and in-order writeback controller for the pipelined
// LAT-cycle W x W multiplier (Mul) living in the execute stage.
// Build option: define MUL_SIGNED_EN to support signed MULT (operands are sent
// to Mul as magnitudes and the product is negated at retire). Without it every
// operation is unsigned and op_signed is ignored.
// Ports:
//   Clk, Rst           : clock (rising edge), asynchronous active-low reset
//   start, op_signed   : issue a multiply this cycle / signed mode
//   a, b               : operands
//   flush              : kill all in-flight multiplies at the next edge
//   mthi, mtlo, wdata  : direct writes of HI / LO
//   mf_req             : pipeline wants to read HI/LO this cycle
//   mul_a, mul_b       : operands driven to Mul
//   mul_y              : product returned by Mul, LAT clocks after operands
//   busy               : at least one multiply in flight
//   stall              : MFHI/MFLO must wait
//   hi, lo             : architectural HI/LO
//   done               : one-cycle pulse when HI/LO take a product
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned LAT = MUL_LAT,
  parameter int unsigned W   = MUL_W
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           start,
  input  logic           op_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           flush,
  input  logic           mthi,
  input  logic           mtlo,
  input  logic [W-1:0]   wdata,
  input  logic           mf_req,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y,
  output logic           busy,
  output logic           stall,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           done
);

  logic [LAT-1:0] vpipe_q, vpipe_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;
  logic [2*W-1:0] prod_fix;
  logic           retire;

  assign retire = vpipe_q[LAT-1];

`ifdef MUL_SIGNED_EN
  logic [LAT-1:0] spipe_q, spipe_d;
  logic           sign_in;

  always_comb begin
    mul_a   = a;
    mul_b   = b;
    sign_in = 1'b0;
    if (op_signed) begin
      mul_a   = a[W-1] ? (~a) + {{(W-1){1'b0}}, 1'b1} : a;
      mul_b   = b[W-1] ? (~b) + {{(W-1){1'b0}}, 1'b1} : b;
      sign_in = a[W-1] ^ b[W-1];
    end
  end

  // Sign bits travel alongside the valid bits; flush only needs to clear
  // vpipe since a sign without a valid bit is never used.
  assign spipe_d = {spipe_q[LAT-2:0], sign_in};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      spipe_q <= '0;
    end else begin
      spipe_q <= spipe_d;
    end
  end

  mul_sign_fix #(
    .PW(2 * W)
  ) u_sign_fix (
    .neg_i (spipe_q[LAT-1]),
    .prod_i(mul_y),
    .prod_o(prod_fix)
  );
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign mul_a            = a;
  assign mul_b            = b;
  assign prod_fix         = mul_y;
`endif

  always_comb begin
    vpipe_d = flush ? '0 : {vpipe_q[LAT-2:0], start};
    done_d  = retire;
    hi_d    = hi_q;
    lo_d    = lo_q;
    // Retire first so that a same-cycle MT write overrides its half only.
    if (retire) begin
      hi_d = prod_fix[2*W-1:W];
      lo_d = prod_fix[W-1:0];
    end
    if (mthi) hi_d = wdata;
    if (mtlo) lo_d = wdata;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vpipe_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      vpipe_q <= vpipe_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = |vpipe_q;
  assign stall = mf_req & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
module tb_mul_hilo_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        mf_req = 1'b0;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_y;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  mul_hilo_ctrl #(
    .LAT(2),
    .W  (32)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .op_signed(op_signed),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .mf_req   (mf_req),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_y    (mul_y),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  // Two-stage unsigned multiplier standing in for the execute-stage Mul.
  logic [63:0] m_s1 = '0;
  logic [63:0] m_s2 = '0;
  always @(posedge Clk) begin
    m_s1 <= {32'd0, mul_a} * {32'd0, mul_b};
    m_s2 <= m_s1;
  end
  assign mul_y = m_s2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs driven here belong to
  // the new cycle, and checks are made after a short settle.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sg);
    start = 1'b1;
    a = av;
    b = bv;
    op_signed = sg;
  endtask

  task automatic idle();
    start = 1'b0;
    a = '0;
    b = '0;
    op_signed = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    Rst = 1'b0;
    mf_req = 1'b1;
    repeat (2) tick();
    settle();
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
    tick();
    Rst = 1'b1;
    tick();

    // 1: single unsigned 3*5
    issue(32'd3, 32'd5, 1'b0);
    tick(); idle(); settle();
    chk("t1_busy_T1", {63'd0, busy}, 64'd1);
    chk("t1_done_T1", {63'd0, done}, 64'd0);
    tick(); settle();
    chk("t1_busy_T2", {63'd0, busy}, 64'd1);
    tick(); settle();
    chk("t1_hi", {32'd0, hi}, 64'd0);
    chk("t1_lo", {32'd0, lo}, 64'd15);
    chk("t1_done_T3", {63'd0, done}, 64'd1);
    chk("t1_busy_T3", {63'd0, busy}, 64'd0);
    tick(); settle();
    chk("t1_done_T4", {63'd0, done}, 64'd0);

    // 2: back-to-back, max unsigned operands then 2*7
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick(); issue(32'd2, 32'd7, 1'b0);
    tick(); idle();
    tick(); settle();
    chk("t2_hi_a", {32'd0, hi}, 64'hFFFF_FFFE);
    chk("t2_lo_a", {32'd0, lo}, 64'h0000_0001);
    chk("t2_done_a", {63'd0, done}, 64'd1);
    tick(); settle();
    chk("t2_hi_b", {32'd0, hi}, 64'd0);
    chk("t2_lo_b", {32'd0, lo}, 64'd14);
    chk("t2_done_b", {63'd0, done}, 64'd1);
    tick(); settle();
    chk("t2_done_c", {63'd0, done}, 64'd0);

    // 3: signed ops (or op_signed ignored in the unsigned build)
`ifdef MUL_SIGNED_EN
    issue(32'hFFFF_FFFD, 32'd7, 1'b1);
    tick(); issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    tick(); idle();
    tick(); settle();
    chk("t3_hi_neg", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("t3_lo_neg", {32'd0, lo}, 64'hFFFF_FFEB);
    tick(); settle();
    chk("t3_hi_min", {32'd0, hi}, 64'h4000_0000);
    chk("t3_lo_min", {32'd0, lo}, 64'd0);
`else
    issue(32'hFFFF_FFFD, 32'd7, 1'b1);
    tick(); idle();
    tick();
    tick(); settle();
    chk("t3_hi_uns", {32'd0, hi}, 64'h0000_0006);
    chk("t3_lo_uns", {32'd0, lo}, 64'hFFFF_FFEB);
`endif
    tick();

    // 4: stall while a product is in flight
    mf_req = 1'b1;
    issue(32'd3, 32'd5, 1'b0);
    settle();
    chk("t4_stall_T0", {63'd0, stall}, 64'd1);
    tick(); idle(); settle();
    chk("t4_stall_T1", {63'd0, stall}, 64'd1);
    tick(); settle();
    chk("t4_stall_T2", {63'd0, stall}, 64'd1);
    tick(); settle();
    chk("t4_stall_T3", {63'd0, stall}, 64'd0);
    chk("t4_lo_T3", {32'd0, lo}, 64'd15);
    mf_req = 1'b0;
    tick();

    // 5: MTLO in the retire cycle wins for LO only
    issue(32'h0001_0000, 32'h0003_0000, 1'b0);  // product 0x3_0000_0000
    tick(); idle();
    tick(); mtlo = 1'b1; wdata = 32'hABCD;
    tick(); mtlo = 1'b0; wdata = '0; settle();
    chk("t5_lo", {32'd0, lo}, 64'hABCD);
    chk("t5_hi", {32'd0, hi}, 64'd3);
    chk("t5_done", {63'd0, done}, 64'd1);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    tick(); mthi = 1'b0; mtlo = 1'b0; wdata = '0; settle();
    chk("t5_mt_hi", {32'd0, hi}, 64'h55);
    chk("t5_mt_lo", {32'd0, lo}, 64'h55);

    // 6a: flush kills an in-flight op
    issue(32'd9, 32'd9, 1'b0);
    tick(); idle(); flush = 1'b1;
    tick(); flush = 1'b0; settle();
    chk("t6_busy_T2", {63'd0, busy}, 64'd0);
    tick(); settle();
    chk("t6_done_T3", {63'd0, done}, 64'd0);
    chk("t6_hi_T3", {32'd0, hi}, 64'h55);
    chk("t6_lo_T3", {32'd0, lo}, 64'h55);

    // 6b: start together with flush is discarded
    issue(32'd4, 32'd4, 1'b0); flush = 1'b1;
    tick(); idle(); flush = 1'b0; settle();
    chk("t6_sf_busy", {63'd0, busy}, 64'd0);
    tick(); tick(); settle();
    chk("t6_sf_done", {63'd0, done}, 64'd0);
    chk("t6_sf_lo", {32'd0, lo}, 64'h55);

    // 6c: flush in the retire cycle still commits the retiring op
    issue(32'd2, 32'd3, 1'b0);
    tick(); idle();
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; settle();
    chk("t6_rf_lo", {32'd0, lo}, 64'd6);
    chk("t6_rf_done", {63'd0, done}, 64'd1);

    // 6d: async reset mid-operation
    tick();
    issue(32'd9, 32'd9, 1'b0);
    tick(); idle(); Rst = 1'b0;
    #1;
    chk("t6_ar_lo", {32'd0, lo}, 64'd0);
    chk("t6_ar_busy", {63'd0, busy}, 64'd0);
    chk("t6_ar_done", {63'd0, done}, 64'd0);
    tick(); Rst = 1'b1;
    tick(); tick(); settle();
    chk("t6_ar_done2", {63'd0, done}, 64'd0);
    chk("t6_ar_lo2", {32'd0, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
